// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if
//   Bundles the requester-side and display-side signals of seg_display_arbiter.
//   master : requester/display side (drives req/val/sgn, observes gnt and digits)
//   slave  : the arbiter itself
//   Signals:
//     req0/req1       requester wants the display
//     val0/val1 [7:0] value to show
//     sgn0/sgn1       1 = value is two's complement
//     gnt0/gnt1       requester owns the display
//     dig_bin [15:0]  {d3,d2,d1,d0} digit codes to the SSeg instances
//     dig_neg [3:0]   per-digit minus-sign select
//     dig_en  [3:0]   per-digit enable (0 = blank)
//   Optional (SEG_DISPLAY_ARBITER_HEX_EN defined):
//     hex0/hex1       1 = show the requester's value as two hex digits
interface seg_display_arbiter_if;
    logic        req0;
    logic [7:0]  val0;
    logic        sgn0;
    logic        req1;
    logic [7:0]  val1;
    logic        sgn1;
    logic        gnt0;
    logic        gnt1;
    logic [15:0] dig_bin;
    logic [3:0]  dig_neg;
    logic [3:0]  dig_en;
`ifdef SEG_DISPLAY_ARBITER_HEX_EN
    logic        hex0;
    logic        hex1;

    modport master (
        output req0, val0, sgn0, hex0, req1, val1, sgn1, hex1,
        input  gnt0, gnt1, dig_bin, dig_neg, dig_en
    );
    modport slave (
        input  req0, val0, sgn0, hex0, req1, val1, sgn1, hex1,
        output gnt0, gnt1, dig_bin, dig_neg, dig_en
    );
`else
    modport master (
        output req0, val0, sgn0, req1, val1, sgn1,
        input  gnt0, gnt1, dig_bin, dig_neg, dig_en
    );
    modport slave (
        input  req0, val0, sgn0, req1, val1, sgn1,
        output gnt0, gnt1, dig_bin, dig_neg, dig_en
    );
`endif
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Shares one 4-digit 7-segment bank between two requesters. Round-robin
//   arbitration with a minimum dwell (HOLD_CYCLES) and an all-blank gap
//   (GAP_CYCLES) between owners. The owner's 8-bit value is shown as
//   sign + 3 decimal digits produced by an iterative double-dabble engine
//   (LOAD, 8 SHIFT, COMMIT = 10-cycle refresh).
//   Ports:
//     Clk    system clock
//     Reset  synchronous, active-high reset
//     bus    seg_display_arbiter_if.slave (requests, values, grants, digits)
//   Optional feature macro: SEG_DISPLAY_ARBITER_HEX_EN
//     adds bus.hex0/bus.hex1; when the owner's hex bit is set the value is
//     committed every cycle as two hex digits instead of decimal.
module seg_display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 2_500_000,
    parameter int unsigned CNT_W       = 26
) (
    input logic                  Clk,
    input logic                  Reset,
    seg_display_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1,
        GAP
    } state_t;

    // Last cycle index of a dwell/gap; a zero-length setting still spends one cycle.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    logic [3:0]       phase_q, phase_d;
    logic [7:0]       mag_q, mag_d;
    logic [11:0]      bcd_q, bcd_d;
    logic             neg_q, neg_d;

    logic [15:0]      dig_bin_q, dig_bin_d;
    logic [3:0]       dig_neg_q, dig_neg_d;
    logic [3:0]       dig_en_q, dig_en_d;

    logic             win_valid;
    logic             win;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            phase_q   <= '0;
            mag_q     <= '0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            dig_bin_q <= '0;
            dig_neg_q <= '0;
            dig_en_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            phase_q   <= phase_d;
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            dig_bin_q <= dig_bin_d;
            dig_neg_q <= dig_neg_d;
            dig_en_q  <= dig_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: arbitration, dwell and gap timing
    // ------------------------------------------------------------------
    always_comb begin
        win_valid = 1'b0;
        win       = 1'b0;
        if (bus.req0 && bus.req1) begin
            win_valid = 1'b1;
            win       = ~last_q;
        end else if (bus.req0) begin
            win_valid = 1'b1;
            win       = 1'b0;
        end else if (bus.req1) begin
            win_valid = 1'b1;
            win       = 1'b1;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d = win ? OWN1 : OWN0;
                    cnt_d   = '0;
                    last_d  = win;
                end
            end
            OWN0: begin
                if ((cnt_q >= HOLD_LAST) && (!bus.req0 || bus.req1)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (cnt_q < HOLD_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OWN1: begin
                if ((cnt_q >= HOLD_LAST) && (!bus.req1 || bus.req0)) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (cnt_q < HOLD_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                // The gap's last edge doubles as the IDLE arbitration edge.
                if (cnt_q >= GAP_LAST) begin
                    cnt_d = '0;
                    if (win_valid) begin
                        state_d = win ? OWN1 : OWN0;
                        last_d  = win;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Conversion engine and committed digit registers
    // ------------------------------------------------------------------
    logic        keep_own;
    logic [7:0]  cur_val;
    logic        cur_sgn;
    logic [11:0] bcd_adj;
    logic [19:0] shift_w;
    logic        hund_nz;
    logic        tens_nz;
`ifdef SEG_DISPLAY_ARBITER_HEX_EN
    logic        cur_hex;
`endif

    always_comb begin
        phase_d   = phase_q;
        mag_d     = mag_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        dig_bin_d = dig_bin_q;
        dig_neg_d = dig_neg_q;
        dig_en_d  = dig_en_q;

        // Conversion only continues while the same owner is kept across this
        // edge; entering, leaving or any non-owner state discards it.
        keep_own = ((state_q == OWN0) || (state_q == OWN1)) && (state_d == state_q);
        cur_val  = (state_q == OWN1) ? bus.val1 : bus.val0;
        cur_sgn  = (state_q == OWN1) ? bus.sgn1 : bus.sgn0;
`ifdef SEG_DISPLAY_ARBITER_HEX_EN
        cur_hex  = (state_q == OWN1) ? bus.hex1 : bus.hex0;
`endif

        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        shift_w = {bcd_adj, mag_q} << 1;

        hund_nz = |bcd_q[11:8];
        tens_nz = |bcd_q[7:4];

        if (!keep_own) begin
            phase_d   = '0;
            dig_bin_d = '0;
            dig_neg_d = '0;
            dig_en_d  = '0;
`ifdef SEG_DISPLAY_ARBITER_HEX_EN
        end else if (cur_hex) begin
            // Bypass: commit every cycle; decimal restarts from LOAD afterwards.
            phase_d   = '0;
            dig_bin_d = {8'h00, cur_val};
            dig_neg_d = '0;
            dig_en_d  = 4'b0011;
`endif
        end else if (phase_q == 4'd0) begin
            // |-128| = 128 still fits an 8-bit unsigned magnitude.
            neg_d   = cur_sgn && cur_val[7];
            mag_d   = (cur_sgn && cur_val[7]) ? 8'(9'd256 - {1'b0, cur_val}) : cur_val;
            bcd_d   = '0;
            phase_d = 4'd1;
        end else if (phase_q == 4'd9) begin
            dig_bin_d = {4'h0, bcd_q};
            dig_neg_d = {neg_q, 3'b000};
            dig_en_d  = {neg_q, hund_nz, hund_nz || tens_nz, 1'b1};
            phase_d   = '0;
        end else begin
            {bcd_d, mag_d} = shift_w;
            phase_d        = phase_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.gnt0    = (state_q == OWN0);
        bus.gnt1    = (state_q == OWN1);
        bus.dig_bin = dig_bin_q;
        bus.dig_neg = dig_neg_q;
        bus.dig_en  = dig_en_q;
    end

endmodule
